// File: rtl/adc_frame_fifo_writer.sv
// adc_frame_fifo_writer: snapshots NCH ADC channel words on each DRDY rise and
// streams them, optionally behind a {SEQ,TS} header word, into a FIFO write port.
module adc_frame_fifo_writer #(
  parameter int NCH    = 4,
  parameter int W      = 64,
  parameter int HDR_EN = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  DRDY,
  input  logic [NCH-1:0][W-1:0] DATA,
  input  logic                  WRFULL,
  output logic                  WRREQ,
  output logic [W-1:0]          WRDATA,
  output logic                  BUSY,
  output logic                  DROP,
  output logic [15:0]           DROP_CNT
);

  localparam int L  = NCH + HDR_EN;
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int TW = W - 16;
  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] idx_r, idx_s;
  logic          drdy_q_r;
  logic [15:0]   seq_r, hdr_seq_r;
  logic [TW-1:0] ts_r, hdr_ts_r;
  logic [W-1:0]  shadow_r [NCH];
  logic          drop_r;
  logic [15:0]   drop_cnt_r;
  logic          rise_s, last_s, capture_s, overrun_s;
  logic [W-1:0]  word_s;

  // A rise is accepted when idle or on the very edge the last word leaves
  always_comb begin
    rise_s    = DRDY & ~drdy_q_r;
    last_s    = (state_r == WRITE) && (idx_r == LAST_IDX) && !WRFULL;
    capture_s = rise_s && ((state_r == IDLE) || last_s);
    overrun_s = rise_s && !capture_s;
  end

  // Next-state and word index
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_s = WRITE;
          idx_s   = {IW{1'b0}};
        end else begin
          state_s = IDLE;
          idx_s   = idx_r;
        end
      end
      WRITE: begin
        if (capture_s) begin
          state_s = WRITE;
          idx_s   = {IW{1'b0}};
        end else if (last_s) begin
          state_s = IDLE;
          idx_s   = {IW{1'b0}};
        end else if (!WRFULL) begin
          state_s = WRITE;
          idx_s   = idx_r + IW'(1'b1);
        end else begin
          state_s = WRITE;
          idx_s   = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IW{1'b0}};
      end
    endcase
  end

  // Outgoing word selected from registered header/shadow state only
  always_comb begin
    word_s = {W{1'b0}};
    if (state_r == WRITE) begin
      if ((HDR_EN != 0) && (idx_r == {IW{1'b0}})) begin
        word_s = {hdr_seq_r, hdr_ts_r};
      end else begin
        for (int i = 0; i < NCH; i++) begin
          word_s = (int'(idx_r) == (i + HDR_EN)) ? shadow_r[i] : word_s;
        end
      end
    end else begin
      word_s = {W{1'b0}};
    end
  end

  // Output mapping; WRREQ follows WRFULL combinationally
  always_comb begin
    WRREQ    = (state_r == WRITE) && !WRFULL;
    WRDATA   = word_s;
    BUSY     = (state_r == WRITE);
    DROP     = drop_r;
    DROP_CNT = drop_cnt_r;
  end

  // Control, counters and header capture
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r    <= IDLE;
      idx_r      <= {IW{1'b0}};
      drdy_q_r   <= 1'b1;
      seq_r      <= 16'h0000;
      ts_r       <= {TW{1'b0}};
      hdr_seq_r  <= 16'h0000;
      hdr_ts_r   <= {TW{1'b0}};
      drop_r     <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      drdy_q_r <= DRDY;
      ts_r     <= ts_r + TW'(1'b1);
      drop_r   <= overrun_s;
      if (overrun_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      if (capture_s) begin
        seq_r     <= seq_r + 16'd1;
        hdr_seq_r <= seq_r;
        hdr_ts_r  <= ts_r;
      end else begin
        seq_r     <= seq_r;
        hdr_seq_r <= hdr_seq_r;
        hdr_ts_r  <= hdr_ts_r;
      end
    end
  end

  // Channel shadow registers, loaded only on capture
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NCH; i++) shadow_r[i] <= {W{1'b0}};
    end else if (capture_s) begin
      for (int i = 0; i < NCH; i++) shadow_r[i] <= DATA[i];
    end else begin
      for (int i = 0; i < NCH; i++) shadow_r[i] <= shadow_r[i];
    end
  end

endmodule
